// File: rtl/cpu_mc_if.sv
// Shared instruction/data memory port: req/ready handshake, any latency tolerated.
interface cpu_mc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit-ISA cpu; ALU/branch 2 cycles, LW/SW 3 cycles at zero wait.
// Memory backpressure: request held with stable address/data until mem_ready; each wait cycle adds one.
module cpu_mc #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  cpu_mc_if.master             mem,
  input  logic                 resume,
  output logic                 halted,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_HALT = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR   = 4'd4, OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7,
                         OP_BEQ  = 4'd8, OP_J = 4'd9;

  state_t                 state_q, state_d;
  logic                   started_q;
  logic [ADDR_W-1:0]      pc_q, pc_d, ea_q, ea_d;
  logic [15:0]            instr_q;
  logic [DATA_W-1:0]      rf_q [8];
  logic                   illegal_q, illegal_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  logic                   xfer;
  logic [3:0]             op;
  logic [2:0]             ra, rb, rc;
  logic [DATA_W-1:0]      va, vb, vc, simm, alu_res;
  logic [ADDR_W-1:0]      pc_inc, br_off;
  logic [INSTRET_W-1:0]   instret_inc;
  logic                   rf_we;
  logic [DATA_W-1:0]      rf_wd;

  assign op          = instr_q[15:12];
  assign ra          = instr_q[11:9];
  assign rb          = instr_q[8:6];
  assign rc          = instr_q[5:3];
  assign va          = (ra == 3'd0) ? '0 : rf_q[ra];
  assign vb          = (rb == 3'd0) ? '0 : rf_q[rb];
  assign vc          = (rc == 3'd0) ? '0 : rf_q[rc];
  assign simm        = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};
  assign br_off      = {{(ADDR_W-6){instr_q[5]}}, instr_q[5:0]};
  assign pc_inc      = pc_q + ADDR_W'(1);
  assign instret_inc = instret_q + INSTRET_W'(1);
  assign xfer        = mem.mem_req & mem.mem_ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (xfer) state_d = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_BEQ, OP_J: state_d = S_FETCH;
          OP_LW, OP_SW:                                         state_d = S_MEM;
          default:                                              state_d = S_HALT;
        endcase
      end
      S_MEM:   if (xfer) state_d = S_FETCH;
      S_HALT:  if (resume) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // started_q keeps the port quiet until the first edge after reset release
  always_comb begin
    mem.mem_req   = started_q && ((state_q == S_FETCH) || (state_q == S_MEM));
    mem.mem_we    = (state_q == S_MEM) && (op == OP_SW);
    mem.mem_addr  = (state_q == S_MEM) ? ea_q : pc_q;
    mem.mem_wdata = va;
    halted        = (state_q == S_HALT);
  end

  always_comb begin
    case (op)
      OP_ADD:  alu_res = vb + vc;
      OP_SUB:  alu_res = vb - vc;
      OP_AND:  alu_res = vb & vc;
      OP_OR:   alu_res = vb | vc;
      default: alu_res = vb + simm;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    ea_d      = ea_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    rf_we     = 1'b0;
    rf_wd     = alu_res;
    case (state_q)
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            rf_we     = 1'b1;
            pc_d      = pc_inc;
            instret_d = instret_inc;
          end
          OP_LW, OP_SW: ea_d = ADDR_W'(vb + simm);
          OP_BEQ: begin
            pc_d      = (va == vb) ? pc_inc + br_off : pc_inc;
            instret_d = instret_inc;
          end
          OP_J: begin
            pc_d      = ADDR_W'(instr_q[11:0]);
            instret_d = instret_inc;
          end
          OP_HALT: ;
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (xfer) begin
          rf_we     = (op == OP_LW);
          rf_wd     = mem.mem_rdata;
          pc_d      = pc_inc;
          instret_d = instret_inc;
        end
      end
      S_HALT: begin
        if (resume) begin
          pc_d      = pc_inc;
          illegal_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      started_q <= 1'b0;
      pc_q      <= RESET_PC;
      ea_q      <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      started_q <= 1'b1;
      pc_q      <= pc_d;
      ea_q      <= ea_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
      if ((state_q == S_FETCH) && xfer) instr_q <= mem.mem_rdata[15:0];
      if (rf_we && (ra != 3'd0)) rf_q[ra] <= rf_wd;
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: a 16-bit instance with a wait-state memory and a 32/12-bit instance.
module tb_cpu_mc;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_a = 1'b1, rst_b = 1'b1, res_a = 1'b0, res_b = 1'b0;
  logic        halted_a, illegal_a, halted_b, illegal_b;
  logic [31:0] instret_a, instret_b;

  cpu_mc_if #(.DATA_W(16), .ADDR_W(16)) ifa ();
  cpu_mc_if #(.DATA_W(32), .ADDR_W(12)) ifb ();

  cpu_mc #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0), .INSTRET_W(32)) dut_a (
    .CLK(CLK), .RST(rst_a), .mem(ifa.master), .resume(res_a),
    .halted(halted_a), .illegal(illegal_a), .instret(instret_a));

  cpu_mc #(.DATA_W(32), .ADDR_W(12), .RESET_PC(12'h0), .INSTRET_W(32)) dut_b (
    .CLK(CLK), .RST(rst_b), .mem(ifb.master), .resume(res_b),
    .halted(halted_b), .illegal(illegal_b), .instret(instret_b));

  int          total = 0, bad = 0;
  logic [15:0] prog[$];
  logic        ld_en = 1'b0, ld_sel = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_dat = '0;

  // memory A: programmable wait states, access counters, stability monitor
  logic [15:0] mem_a [256];
  int          wait_a = 0, cnt_a = 0, rd_cnt_a = 0, wr_cnt_a = 0, unstable_a = 0;
  logic [15:0] last_rd_a = '0, p_addr_a = '0, p_wdat_a = '0;
  logic        pend_a = 1'b0, p_we_a = 1'b0;

  assign ifa.mem_ready = ifa.mem_req && (cnt_a >= wait_a);
  assign ifa.mem_rdata = mem_a[ifa.mem_addr[7:0]];

  always @(posedge CLK) begin
    if (clr_a) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= '0;
      rd_cnt_a <= 0; wr_cnt_a <= 0; unstable_a <= 0; cnt_a <= 0;
    end else begin
      if (ld_en && !ld_sel) mem_a[ld_addr] <= ld_dat[15:0];
      if (ifa.mem_req && ifa.mem_ready) begin
        cnt_a <= 0;
        if (ifa.mem_we) begin
          mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
          wr_cnt_a <= wr_cnt_a + 1;
        end else begin
          rd_cnt_a  <= rd_cnt_a + 1;
          last_rd_a <= ifa.mem_addr;
        end
      end else if (ifa.mem_req) cnt_a <= cnt_a + 1;
      else cnt_a <= 0;
      if (pend_a && rst_a && (!ifa.mem_req || ifa.mem_addr != p_addr_a || ifa.mem_we != p_we_a ||
                              (p_we_a && ifa.mem_wdata != p_wdat_a)))
        unstable_a <= unstable_a + 1;
    end
    pend_a   <= ifa.mem_req && !ifa.mem_ready && rst_a;
    p_addr_a <= ifa.mem_addr;
    p_we_a   <= ifa.mem_we;
    p_wdat_a <= ifa.mem_wdata;
  end

  // memory B: zero-wait
  logic [31:0] mem_b [256];
  assign ifb.mem_ready = ifb.mem_req;
  assign ifb.mem_rdata = mem_b[ifb.mem_addr[7:0]];

  always @(posedge CLK) begin
    if (clr_b) for (int i = 0; i < 256; i++) mem_b[i] <= '0;
    else if (ld_en && ld_sel) mem_b[ld_addr] <= ld_dat;
    else if (ifb.mem_req && ifb.mem_we) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_wdata;
  end

  // upper half of each loaded instruction word is junk: only [15:0] may be decoded
  task automatic load_prog(input logic sel);
    for (int i = 0; i < prog.size(); i++) begin
      ld_en = 1'b1; ld_sel = sel; ld_addr = 8'(i); ld_dat = {16'hDEAD, prog[i]};
      @(negedge CLK);
    end
    ld_en = 1'b0;
  endtask

  task automatic poke(input logic sel, input logic [7:0] addr, input logic [31:0] dat);
    ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_dat = dat;
    @(negedge CLK);
    ld_en = 1'b0;
  endtask

  task automatic clear(input logic sel);
    if (sel) clr_b = 1'b1; else clr_a = 1'b1;
    @(negedge CLK);
    clr_a = 1'b0; clr_b = 1'b0;
  endtask

  task automatic go(input logic sel);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_halt(input logic sel, output int cyc);
    cyc = 0;
    while (!(sel ? halted_b : halted_a) && cyc < 2000) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 2000) begin
      $display("FAIL run_timeout: dut=%0d still not halted after %0d cycles", sel, cyc);
      bad++; total++;
    end
  endtask

  task automatic test_reset;
    if (ifa.mem_req !== 1'b0) begin $display("FAIL rst_req: got %b want 0", ifa.mem_req); bad++; end
    total++;
    if (ifa.mem_we !== 1'b0) begin $display("FAIL rst_we: got %b want 0", ifa.mem_we); bad++; end
    total++;
    if (halted_a !== 1'b0) begin $display("FAIL rst_halted: got %b want 0", halted_a); bad++; end
    total++;
    if (illegal_a !== 1'b0) begin $display("FAIL rst_illegal: got %b want 0", illegal_a); bad++; end
    total++;
    if (instret_a !== 32'd0) begin $display("FAIL rst_instret: got %0d want 0", instret_a); bad++; end
    total++;
    if (ifb.mem_req !== 1'b0) begin $display("FAIL rst_req_b: got %b want 0", ifb.mem_req); bad++; end
    total++;
  endtask

  task automatic test_halt;
    int cyc;
    wait_a = 0;
    clear(1'b0);
    go(1'b0);
    if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 16'h0) begin
      $display("FAIL first_fetch: req=%b addr=%h want req=1 addr=0000", ifa.mem_req, ifa.mem_addr); bad++;
    end
    total++;
    run_halt(1'b0, cyc);
    if (cyc !== 2) begin $display("FAIL halt_cycles: got %0d want 2", cyc); bad++; end
    total++;
    repeat (10) @(negedge CLK);
    if (halted_a !== 1'b1 || ifa.mem_req !== 1'b0) begin
      $display("FAIL halt_hold: halted=%b req=%b want 1 0", halted_a, ifa.mem_req); bad++;
    end
    total++;
    if (rd_cnt_a !== 1 || last_rd_a !== 16'h0) begin
      $display("FAIL halt_fetches: count=%0d last=%h want 1 0000", rd_cnt_a, last_rd_a); bad++;
    end
    total++;
    if (instret_a !== 32'd0 || illegal_a !== 1'b0) begin
      $display("FAIL halt_counts: instret=%0d illegal=%b want 0 0", instret_a, illegal_a); bad++;
    end
    total++;
  endtask

  task automatic test_alu;
    int cyc;
    rst_a = 1'b0; @(negedge CLK);
    clear(1'b0);
    prog = '{16'h5201, 16'h7214, 16'h1248, 16'h7215, 16'h5222, 16'h7216, 16'h0000};
    load_prog(1'b0);
    go(1'b0);
    run_halt(1'b0, cyc);
    if (cyc !== 17) begin $display("FAIL alu_cycles: got %0d want 17", cyc); bad++; end
    total++;
    if (mem_a[20] !== 16'h0001 || mem_a[21] !== 16'h0002 || mem_a[22] !== 16'hFFE2) begin
      $display("FAIL alu_r1: got %h %h %h want 0001 0002 ffe2", mem_a[20], mem_a[21], mem_a[22]); bad++;
    end
    total++;
    if (instret_a !== 32'd6 || last_rd_a !== 16'd6) begin
      $display("FAIL alu_retire: instret=%0d pc=%0d want 6 6", instret_a, last_rd_a); bad++;
    end
    total++;
  endtask

  task automatic test_branch;
    int cyc;
    rst_a = 1'b0; @(negedge CLK);
    clear(1'b0);
    prog = '{16'h5205, 16'h8202, 16'h8001, 16'h5407, 16'h9006,
             16'h5409, 16'h7414, 16'h5003, 16'h7015, 16'h0000};
    load_prog(1'b0);
    poke(1'b0, 8'd20, 32'hAAAA);
    poke(1'b0, 8'd21, 32'hBBBB);
    go(1'b0);
    run_halt(1'b0, cyc);
    if (mem_a[20] !== 16'h0000) begin $display("FAIL branch_r2: got %h want 0000", mem_a[20]); bad++; end
    total++;
    if (mem_a[21] !== 16'h0000) begin $display("FAIL branch_r0: got %h want 0000", mem_a[21]); bad++; end
    total++;
    if (last_rd_a !== 16'd9 || rd_cnt_a !== 8 || instret_a !== 32'd7) begin
      $display("FAIL branch_path: pc=%0d fetches=%0d instret=%0d want 9 8 7", last_rd_a, rd_cnt_a, instret_a);
      bad++;
    end
    total++;
  endtask

  task automatic test_waits;
    int cyc;
    rst_a = 1'b0; @(negedge CLK);
    clear(1'b0);
    prog = '{16'h5218, 16'h1248, 16'h1248, 16'h1248, 16'h1248, 16'h1248, 16'h1248,
             16'h1248, 16'h1248, 16'h1248, 16'h1248, 16'h5242, 16'h721F, 16'h641F,
             16'h741E, 16'h0000};
    load_prog(1'b0);
    wait_a = 3;
    go(1'b0);
    run_halt(1'b0, cyc);
    if (cyc !== 92) begin $display("FAIL wait_cycles: got %0d want 92", cyc); bad++; end
    total++;
    if (mem_a[31] !== 16'h6002 || mem_a[30] !== 16'h6002) begin
      $display("FAIL wait_data: M31=%h r2=%h want 6002 6002", mem_a[31], mem_a[30]); bad++;
    end
    total++;
    if (unstable_a !== 0) begin $display("FAIL wait_stable: got %0d changes want 0", unstable_a); bad++; end
    total++;
    if (instret_a !== 32'd15 || wr_cnt_a !== 2) begin
      $display("FAIL wait_counts: instret=%0d writes=%0d want 15 2", instret_a, wr_cnt_a); bad++;
    end
    total++;
    wait_a = 0;
  endtask

  task automatic test_illegal;
    int cyc;
    rst_a = 1'b0; @(negedge CLK);
    clear(1'b0);
    prog = '{16'h5201, 16'h5241, 16'h5241, 16'h5241, 16'hF000, 16'h7214, 16'h0000};
    load_prog(1'b0);
    go(1'b0);
    run_halt(1'b0, cyc);
    if (illegal_a !== 1'b1 || halted_a !== 1'b1 || last_rd_a !== 16'd4 || instret_a !== 32'd4) begin
      $display("FAIL illegal_stop: illegal=%b halted=%b pc=%0d instret=%0d want 1 1 4 4",
               illegal_a, halted_a, last_rd_a, instret_a);
      bad++;
    end
    total++;
    res_a = 1'b1; @(negedge CLK); res_a = 1'b0;
    if (illegal_a !== 1'b0 || halted_a !== 1'b0 || ifa.mem_req !== 1'b1 || ifa.mem_addr !== 16'd5) begin
      $display("FAIL resume: illegal=%b halted=%b req=%b addr=%0d want 0 0 1 5",
               illegal_a, halted_a, ifa.mem_req, ifa.mem_addr);
      bad++;
    end
    total++;
    run_halt(1'b0, cyc);
    if (mem_a[20] !== 16'd4 || instret_a !== 32'd5 || last_rd_a !== 16'd6) begin
      $display("FAIL resume_run: r1=%0d instret=%0d pc=%0d want 4 5 6", mem_a[20], instret_a, last_rd_a);
      bad++;
    end
    total++;
  endtask

  task automatic test_reset_mid;
    int cyc, n;
    rst_a = 1'b0; @(negedge CLK);
    clear(1'b0);
    prog = '{16'h5205, 16'h7214, 16'h0000};
    load_prog(1'b0);
    poke(1'b0, 8'd20, 32'h1111);
    wait_a = 3;
    go(1'b0);
    n = 0;
    while (!(ifa.mem_req && ifa.mem_we) && n < 100) begin @(negedge CLK); n++; end
    if (ifa.mem_we !== 1'b1 || ifa.mem_addr !== 16'd20 || ifa.mem_wdata !== 16'd5) begin
      $display("FAIL sw_issue: we=%b addr=%0d wdata=%h want 1 20 0005", ifa.mem_we, ifa.mem_addr, ifa.mem_wdata);
      bad++;
    end
    total++;
    #1 rst_a = 1'b0;
    #1;
    if (ifa.mem_req !== 1'b0) begin $display("FAIL abort_req: got %b want 0", ifa.mem_req); bad++; end
    total++;
    @(negedge CLK); @(negedge CLK);
    if (mem_a[20] !== 16'h1111 || wr_cnt_a !== 0) begin
      $display("FAIL abort_write: M20=%h writes=%0d want 1111 0", mem_a[20], wr_cnt_a); bad++;
    end
    total++;
    clear(1'b0);
    prog = '{16'h7215, 16'h0000};
    load_prog(1'b0);
    poke(1'b0, 8'd21, 32'h2222);
    wait_a = 0;
    go(1'b0);
    if (ifa.mem_req !== 1'b1 || ifa.mem_addr !== 16'h0) begin
      $display("FAIL restart_pc: req=%b addr=%h want 1 0000", ifa.mem_req, ifa.mem_addr); bad++;
    end
    total++;
    run_halt(1'b0, cyc);
    if (mem_a[21] !== 16'h0000 || instret_a !== 32'd1) begin
      $display("FAIL restart_state: r1=%h instret=%0d want 0000 1", mem_a[21], instret_a); bad++;
    end
    total++;
  endtask

  task automatic test_wide;
    int cyc;
    clear(1'b1);
    prog = '{16'h5201, 16'h7214, 16'h1248, 16'h7215, 16'h5222, 16'h7216, 16'h0000};
    load_prog(1'b1);
    go(1'b1);
    run_halt(1'b1, cyc);
    if (mem_b[20] !== 32'd1 || mem_b[21] !== 32'd2 || mem_b[22] !== 32'hFFFFFFE2) begin
      $display("FAIL wide_r1: got %h %h %h want 00000001 00000002 ffffffe2", mem_b[20], mem_b[21], mem_b[22]);
      bad++;
    end
    total++;
    if (instret_b !== 32'd6 || illegal_b !== 1'b0 || cyc !== 17) begin
      $display("FAIL wide_retire: instret=%0d illegal=%b cycles=%0d want 6 0 17", instret_b, illegal_b, cyc);
      bad++;
    end
    total++;
  endtask

  initial begin
    #2 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge CLK);
    test_reset;
    test_halt;
    test_alu;
    test_branch;
    test_waits;
    test_illegal;
    test_reset_mid;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
